// File: rtl/control_decode_seq.sv
// Registered control decoder: turns a sampled device-select code into one-cycle
// active-low load strobes, conditional jumps and a UART wait/stall sequence.
module control_decode_seq #(
  parameter int DEV_WIDTH    = 6,
  parameter int REG_SEL_W    = DEV_WIDTH - 1,
  parameter int TIMEOUT_W    = 8,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 _mr,
  input  logic [DEV_WIDTH-1:0] device_in,
  input  logic                 _dev_valid,
  input  logic                 _flag_z,
  input  logic                 _flag_c,
  input  logic                 _flag_o,
  input  logic                 _flag_eq,
  input  logic                 _flag_ne,
  input  logic                 _flag_gt,
  input  logic                 _flag_lt,
  input  logic                 _flags_we,
  input  logic                 _uart_in_ready,
  input  logic                 _uart_out_ready,
  output logic                 _ram_in,
  output logic                 _marlo_in,
  output logic                 _marhi_in,
  output logic                 _uart_in,
  output logic                 _pchitmp_in,
  output logic                 _pclo_in,
  output logic                 _pc_in,
  output logic                 _reg_in,
  output logic [REG_SEL_W-1:0] reg_sel,
  output logic                 _jump_taken,
  output logic                 _stall,
  output logic                 _timeout_err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam int STB_RAM = 0, STB_MARLO = 1, STB_MARHI = 2, STB_UART = 3;
  localparam int STB_PCHI = 4, STB_PCLO = 5, STB_PC = 6, STB_REG = 7;
  localparam int F_Z = 0, F_C = 1, F_O = 2, F_EQ = 3, F_NE = 4, F_GT = 5, F_LT = 6;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 wait_out_q, wait_out_d;
  logic [6:0]           flags_q, flags_d, flags_in;
  logic [7:0]           strobe_q, strobe_d;
  logic [REG_SEL_W-1:0] reg_sel_q, reg_sel_d;
  logic                 jump_q, jump_d;
  logic                 terr_q, terr_d;
  logic                 jump_cond;
  logic                 wait_ready;

  assign flags_in = {_flag_lt, _flag_gt, _flag_ne, _flag_eq, _flag_o, _flag_c, _flag_z};

  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wait_out_q <= 1'b0;
      flags_q    <= '1;
      strobe_q   <= '1;
      reg_sel_q  <= '0;
      jump_q     <= 1'b1;
      terr_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_out_q <= wait_out_d;
      flags_q    <= flags_d;
      strobe_q   <= strobe_d;
      reg_sel_q  <= reg_sel_d;
      jump_q     <= jump_d;
      terr_q     <= terr_d;
    end
  end

  // flags_d doubles as the forwarded condition source when a flag write coincides with a jump
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_out_d = wait_out_q;
    strobe_d   = '1;
    reg_sel_d  = reg_sel_q;
    jump_d     = 1'b1;
    terr_d     = terr_q;
    jump_cond  = 1'b0;
    flags_d    = _flags_we ? flags_q : flags_in;
    wait_ready = wait_out_q ? _uart_out_ready : _uart_in_ready;
    case (state_q)
      S_IDLE: begin
        if (!_dev_valid) begin
          if (device_in[DEV_WIDTH-1:5] != '0) begin
            strobe_d[STB_REG] = 1'b0;
            reg_sel_d         = device_in[REG_SEL_W-1:0];
          end else begin
            case (device_in[4:0])
              5'd0:  strobe_d[STB_RAM]   = 1'b0;
              5'd1:  strobe_d[STB_MARLO] = 1'b0;
              5'd2:  strobe_d[STB_MARHI] = 1'b0;
              5'd3:  strobe_d[STB_UART]  = 1'b0;
              5'd4:  strobe_d[STB_PCHI]  = 1'b0;
              5'd5:  strobe_d[STB_PCLO]  = 1'b0;
              5'd6:  strobe_d[STB_PC]    = 1'b0;
              5'd7:  jump_cond = !flags_d[F_O];
              5'd8:  jump_cond = !flags_d[F_Z];
              5'd9:  jump_cond = !flags_d[F_C];
              5'd10: jump_cond = !_uart_in_ready;
              5'd11: jump_cond = !_uart_out_ready;
              5'd12: jump_cond = !flags_d[F_EQ];
              5'd13: jump_cond = !flags_d[F_NE];
              5'd14: jump_cond = !flags_d[F_GT];
              5'd15: jump_cond = !flags_d[F_LT];
              5'd16: begin
                if (_uart_in_ready) begin
                  state_d    = S_WAIT;
                  cnt_d      = '0;
                  wait_out_d = 1'b0;
                end
              end
              5'd17: begin
                if (_uart_out_ready) begin
                  state_d    = S_WAIT;
                  cnt_d      = '0;
                  wait_out_d = 1'b1;
                end
              end
              default: ;
            endcase
            if (jump_cond) begin
              strobe_d[STB_PC] = 1'b0;
              jump_d           = 1'b0;
            end
          end
        end
      end
      S_WAIT: begin
        if (!wait_ready) begin
          state_d = S_IDLE;
        end else if (cnt_q == TIMEOUT_W'(WAIT_TIMEOUT - 1)) begin
          state_d = S_IDLE;
          terr_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    {_reg_in, _pc_in, _pclo_in, _pchitmp_in, _uart_in, _marhi_in, _marlo_in, _ram_in} = strobe_q;
    reg_sel      = reg_sel_q;
    _jump_taken  = jump_q;
    _timeout_err = terr_q;
    _stall       = (state_q != S_WAIT);
  end

endmodule

// File: tb/tb_control_decode_seq.sv
// Directed bench for control_decode_seq: a vector table for single-cycle decode
// plus hand-written WAIT, timeout and reset-during-wait sequences.
module tb_control_decode_seq;

  localparam logic [7:0] NONE = 8'hFF, RAM = 8'hFE, MARLO = 8'hFD, MARHI = 8'hFB;
  localparam logic [7:0] UART = 8'hF7, PCHI = 8'hEF, PCLO = 8'hDF, PC = 8'hBF, REG = 8'h7F;
  localparam logic [6:0] F_ALL = 7'b1111111, F_Z0 = 7'b1111110, F_C0 = 7'b1111101;
  localparam logic [6:0] F_EQ0 = 7'b1110111, F_GT0 = 7'b1011111;

  typedef struct {
    logic [5:0] code;
    logic       valid_n;
    logic       we_n;
    logic [6:0] fl;
    logic       in_rdy;
    logic       out_rdy;
    logic [7:0] exp_stb;
    logic       exp_jmp;
    logic [4:0] exp_sel;
  } vec_t;

  logic       clk, _mr;
  logic [5:0] device_in;
  logic       _dev_valid, _flags_we, _uart_in_ready, _uart_out_ready;
  logic [6:0] fl;
  logic       _ram_in, _marlo_in, _marhi_in, _uart_in, _pchitmp_in, _pclo_in, _pc_in, _reg_in;
  logic [4:0] reg_sel;
  logic       _jump_taken, _stall, _timeout_err;
  logic [7:0] stb;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass = 0;

  control_decode_seq #(.WAIT_TIMEOUT(6)) dut (
    .clk(clk), ._mr(_mr), .device_in(device_in), ._dev_valid(_dev_valid),
    ._flag_z(fl[0]), ._flag_c(fl[1]), ._flag_o(fl[2]), ._flag_eq(fl[3]),
    ._flag_ne(fl[4]), ._flag_gt(fl[5]), ._flag_lt(fl[6]), ._flags_we(_flags_we),
    ._uart_in_ready(_uart_in_ready), ._uart_out_ready(_uart_out_ready),
    ._ram_in(_ram_in), ._marlo_in(_marlo_in), ._marhi_in(_marhi_in), ._uart_in(_uart_in),
    ._pchitmp_in(_pchitmp_in), ._pclo_in(_pclo_in), ._pc_in(_pc_in), ._reg_in(_reg_in),
    .reg_sel(reg_sel), ._jump_taken(_jump_taken), ._stall(_stall), ._timeout_err(_timeout_err)
  );

  assign stb = {_reg_in, _pc_in, _pclo_in, _pchitmp_in, _uart_in, _marhi_in, _marlo_in, _ram_in};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_output(name, {7'd0, act}, {7'd0, exp});
  endtask

  // Inputs are set just after an edge; outputs are sampled 1 ns after the next edge
  task automatic apply_stimulus(input logic [5:0] c, input logic v, input logic we,
                                input logic [6:0] f, input logic ir, input logic orr);
    device_in = c; _dev_valid = v; _flags_we = we; fl = f;
    _uart_in_ready = ir; _uart_out_ready = orr;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [5:0] c, input logic v, input logic we, input logic [6:0] f,
                     input logic ir, input logic orr, input logic [7:0] es, input logic ej,
                     input logic [4:0] rs);
    vec_t t;
    t.code = c; t.valid_n = v; t.we_n = we; t.fl = f; t.in_rdy = ir; t.out_rdy = orr;
    t.exp_stb = es; t.exp_jmp = ej; t.exp_sel = rs;
    vecs.push_back(t);
  endtask

  initial begin
    add(6'd0,  0, 1, F_ALL, 1, 1, RAM,   1, 5'd0);
    add(6'd1,  0, 1, F_ALL, 1, 1, MARLO, 1, 5'd0);
    add(6'd2,  0, 1, F_ALL, 1, 1, MARHI, 1, 5'd0);
    add(6'd3,  0, 1, F_ALL, 1, 1, UART,  1, 5'd0);
    add(6'd4,  0, 1, F_ALL, 1, 1, PCHI,  1, 5'd0);
    add(6'd5,  0, 1, F_ALL, 1, 1, PCLO,  1, 5'd0);
    add(6'd6,  0, 1, F_ALL, 1, 1, PC,    1, 5'd0);
    add(6'd8,  0, 0, F_Z0,  1, 1, PC,    0, 5'd0);
    add(6'd8,  0, 0, F_ALL, 1, 1, NONE,  1, 5'd0);
    add(6'd8,  0, 1, F_ALL, 1, 1, NONE,  1, 5'd0);
    add(6'd0,  1, 1, F_ALL, 1, 1, NONE,  1, 5'd0);
    add(6'd0,  1, 0, F_C0,  1, 1, NONE,  1, 5'd0);
    add(6'd9,  0, 1, F_ALL, 1, 1, PC,    0, 5'd0);
    add(6'd7,  0, 1, F_ALL, 1, 1, NONE,  1, 5'd0);
    add(6'd12, 0, 0, F_EQ0, 1, 1, PC,    0, 5'd0);
    add(6'd13, 0, 1, F_ALL, 1, 1, NONE,  1, 5'd0);
    add(6'd14, 0, 0, F_GT0, 1, 1, PC,    0, 5'd0);
    add(6'd15, 0, 1, F_ALL, 1, 1, NONE,  1, 5'd0);
    add(6'd14, 0, 1, F_ALL, 1, 1, PC,    0, 5'd0);
    add(6'd10, 0, 1, F_ALL, 0, 1, PC,    0, 5'd0);
    add(6'd11, 0, 1, F_ALL, 1, 1, NONE,  1, 5'd0);
    add(6'd11, 0, 1, F_ALL, 1, 0, PC,    0, 5'd0);
    add(6'd45, 0, 1, F_ALL, 1, 1, REG,   1, 5'd13);
    add(6'd20, 0, 1, F_ALL, 1, 1, NONE,  1, 5'd13);
    add(6'd33, 0, 1, F_ALL, 1, 1, REG,   1, 5'd1);
    add(6'd16, 0, 1, F_ALL, 0, 1, NONE,  1, 5'd1);
    add(6'd63, 0, 1, F_ALL, 1, 1, REG,   1, 5'd31);
    add(6'd0,  0, 1, F_ALL, 1, 1, RAM,   1, 5'd31);
    add(6'd0,  0, 1, F_ALL, 1, 1, RAM,   1, 5'd31);
    add(6'd31, 0, 1, F_ALL, 1, 1, NONE,  1, 5'd31);

    _mr = 1'b0; device_in = '0; _dev_valid = 1'b1; _flags_we = 1'b1; fl = F_ALL;
    _uart_in_ready = 1'b1; _uart_out_ready = 1'b1;
    #12;
    check_output("reset_stb", stb, NONE);
    check_bit("reset_jmp", _jump_taken, 1'b1);
    check_bit("reset_stall", _stall, 1'b1);
    check_bit("reset_terr", _timeout_err, 1'b1);
    check_output("reset_sel", {3'd0, reg_sel}, 8'd0);
    _mr = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].code, vecs[i].valid_n, vecs[i].we_n, vecs[i].fl,
                     vecs[i].in_rdy, vecs[i].out_rdy);
      check_output($sformatf("v%0d_stb", i), stb, vecs[i].exp_stb);
      check_bit($sformatf("v%0d_jmp", i), _jump_taken, vecs[i].exp_jmp);
      check_bit($sformatf("v%0d_stall", i), _stall, 1'b1);
      check_output($sformatf("v%0d_sel", i), {3'd0, reg_sel}, {3'd0, vecs[i].exp_sel});
    end

    // WAITDI: ready arrives after five stalled cycles; codes offered meanwhile are dropped
    apply_stimulus(6'd16, 0, 1, F_ALL, 1, 1);
    check_bit("wdi_stall0", _stall, 1'b0);
    check_output("wdi_stb0", stb, NONE);
    for (int k = 1; k < 5; k++) begin
      apply_stimulus(6'(k), 0, 1, F_ALL, 1, 1);
      check_bit($sformatf("wdi_stall%0d", k), _stall, 1'b0);
      check_output($sformatf("wdi_stb%0d", k), stb, NONE);
    end
    apply_stimulus(6'd0, 1, 1, F_ALL, 0, 1);
    check_bit("wdi_release", _stall, 1'b1);
    check_bit("wdi_terr", _timeout_err, 1'b1);

    // WAITDO: ready lands on the same edge the timeout would fire, so no error
    apply_stimulus(6'd17, 0, 1, F_ALL, 1, 1);
    for (int k = 1; k < 6; k++) begin
      apply_stimulus(6'd0, 1, 1, F_ALL, 1, 1);
      check_bit($sformatf("race_stall%0d", k), _stall, 1'b0);
    end
    apply_stimulus(6'd0, 1, 1, F_ALL, 1, 0);
    check_bit("race_release", _stall, 1'b1);
    check_bit("race_terr", _timeout_err, 1'b1);

    // WAITDO timeout: six stalled cycles, then sticky error
    apply_stimulus(6'd17, 0, 1, F_ALL, 1, 1);
    for (int k = 1; k < 6; k++) begin
      apply_stimulus(6'd0, 1, 1, F_ALL, 1, 1);
      check_bit($sformatf("to_stall%0d", k), _stall, 1'b0);
      check_bit($sformatf("to_terr%0d", k), _timeout_err, 1'b1);
    end
    apply_stimulus(6'd0, 1, 1, F_ALL, 1, 1);
    check_bit("to_release", _stall, 1'b1);
    check_bit("to_terr", _timeout_err, 1'b0);
    apply_stimulus(6'd0, 0, 1, F_ALL, 1, 1);
    check_output("to_after_stb", stb, RAM);
    check_bit("to_sticky", _timeout_err, 1'b0);

    // Asynchronous reset in the middle of a wait
    apply_stimulus(6'd16, 0, 1, F_ALL, 1, 1);
    apply_stimulus(6'd0, 1, 1, F_ALL, 1, 1);
    check_bit("rst_pre_stall", _stall, 1'b0);
    #2;
    _mr = 1'b0;
    #1;
    check_bit("rst_stall", _stall, 1'b1);
    check_bit("rst_terr", _timeout_err, 1'b1);
    check_output("rst_sel", {3'd0, reg_sel}, 8'd0);
    #1;
    _mr = 1'b1;
    apply_stimulus(6'd0, 1, 1, F_ALL, 1, 1);
    check_bit("rst_idle_stall", _stall, 1'b1);
    apply_stimulus(6'd0, 0, 1, F_ALL, 1, 1);
    check_output("rst_idle_stb", stb, RAM);
    check_bit("rst_idle_terr", _timeout_err, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
